// File: rtl/raw8_sensor_emu.sv
// RAW8 CMOS sensor emulator: vsync/hsync/href timing plus built-in Bayer test patterns.
// Define RAW_NOISE_EN to XOR an LFSR into the three LSBs of every active pixel.
module raw8_sensor_emu #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int HSYNC_W   = 2,
    parameter int H_BACK    = 2,
    parameter int H_FRONT   = 2,
    parameter int VSYNC_W   = 4,
    parameter int V_BACK    = 1,
    parameter int V_FRONT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mirror,
    input  logic [1:0]  pattern_sel,
    output logic        frame_vsync,
    output logic        frame_hsync,
    output logic        frame_href,
    output logic [7:0]  img_raw,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = HSYNC_W + H_BACK + IMG_HDISP + H_FRONT;

    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0] HS_END    = 16'(HSYNC_W);
    localparam logic [15:0] ACT_START = 16'(HSYNC_W + H_BACK);
    localparam logic [15:0] ACT_END   = 16'(HSYNC_W + H_BACK + IMG_HDISP);
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_W - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BACK - 1);
    localparam logic [15:0] VA_LAST   = 16'(IMG_VDISP - 1);
    localparam logic [15:0] VF_LAST   = 16'(V_FRONT - 1);
    localparam logic [15:0] BAR_LAST  = 16'(IMG_HDISP / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] line_q, line_d;
    logic [15:0] x_q, x_d;
    logic [15:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  mirror_q, pattern_q;

    logic        line_end, frame_end, frame_start;
    logic        href_c, hsync_c, vsync_c, busy_c;
    logic        py, px, r_bit, g_bit, b_bit, sel_bit;
    logic [7:0]  pat_c, pix_c;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q + 16'd1;
        line_d    = line_q;
        frame_end = 1'b0;
        line_end  = (hcnt_q == H_LAST);
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                line_d = '0;
                if (enable) state_d = S_VSYNC;
            end
            S_VSYNC: begin
                if (hcnt_q == VS_LAST) begin
                    hcnt_d  = '0;
                    state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                end
            end
            S_VBACK: begin
                if (line_end) begin
                    hcnt_d = '0;
                    if (line_q == VB_LAST) begin
                        line_d  = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        line_d = line_q + 16'd1;
                    end
                end
            end
            S_ACTIVE: begin
                if (line_end) begin
                    hcnt_d = '0;
                    if (line_q == VA_LAST) begin
                        line_d = '0;
                        if (V_FRONT > 0) begin
                            state_d = S_VFRONT;
                        end else begin
                            frame_end = 1'b1;
                            state_d   = enable ? S_VSYNC : S_IDLE;
                        end
                    end else begin
                        line_d = line_q + 16'd1;
                    end
                end
            end
            S_VFRONT: begin
                if (line_end) begin
                    hcnt_d = '0;
                    if (line_q == VF_LAST) begin
                        line_d    = '0;
                        frame_end = 1'b1;
                        state_d   = enable ? S_VSYNC : S_IDLE;
                    end else begin
                        line_d = line_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_start = (state_q == S_VSYNC) && (hcnt_q == '0);
    assign href_c  = (state_q == S_ACTIVE) && (hcnt_q >= ACT_START) && (hcnt_q < ACT_END);
    assign vsync_c = (state_q != S_VSYNC);
    assign busy_c  = (state_q != S_IDLE);
    assign hsync_c = (state_q == S_IDLE) ||
                     ((state_q != S_VSYNC) && (hcnt_q >= HS_END));

    // Bar index advances every IMG_HDISP/8 pixels, avoiding a divider on x.
    always_comb begin
        x_d       = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (href_c) begin
            x_d = x_q + 16'd1;
            if (bar_cnt_q == BAR_LAST) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 16'd1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    assign py    = line_q[0] ^ mirror_q[1];
    assign px    = x_q[0] ^ mirror_q[0];
    assign r_bit = ~bar_idx_q[1];
    assign g_bit = ~bar_idx_q[2];
    assign b_bit = ~bar_idx_q[0];

    always_comb begin
        sel_bit = g_bit;
        pat_c   = 8'd0;
        case ({py, px})
            2'b00:   sel_bit = b_bit;
            2'b11:   sel_bit = r_bit;
            default: sel_bit = g_bit;
        endcase
        case (pattern_q)
            2'd0: begin
                case ({py, px})
                    2'b00:   pat_c = 8'd100;
                    2'b11:   pat_c = 8'd200;
                    default: pat_c = 8'd150;
                endcase
            end
            2'd1:    pat_c = sel_bit ? 8'd255 : 8'd0;
            2'd2:    pat_c = x_q[7:0];
            default: pat_c = (x_q[3] ^ line_q[3]) ? 8'd255 : 8'd0;
        endcase
    end

`ifdef RAW_NOISE_EN
    logic [15:0] lfsr_q;

    assign pix_c = href_c ? (pat_c ^ {5'b0, lfsr_q[2:0]}) : 8'd0;

    // Fibonacci taps 16,14,13,11; reseeded each frame so every frame carries the same noise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else if (frame_start) begin
            lfsr_q <= 16'hACE1;
        end else if (href_c) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`else
    assign pix_c = href_c ? pat_c : 8'd0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            line_q      <= '0;
            x_q         <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            mirror_q    <= '0;
            pattern_q   <= '0;
            frame_vsync <= 1'b1;
            frame_hsync <= 1'b1;
            frame_href  <= 1'b0;
            img_raw     <= 8'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            line_q      <= line_d;
            x_q         <= x_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            if (frame_start) begin
                mirror_q  <= mirror;
                pattern_q <= pattern_sel;
            end
            frame_vsync <= vsync_c;
            frame_hsync <= hsync_c;
            frame_href  <= href_c;
            img_raw     <= pix_c;
            busy        <= busy_c;
            frame_done  <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_raw8_sensor_emu.sv
// Scoreboard bench for raw8_sensor_emu: expected pixels and frame counts are queued by
// the stimulus thread and consumed by a monitor whenever href or frame_done is seen.
module tb_raw8_sensor_emu;

    localparam int HD = 16;
    localparam int VD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mirror = 2'd0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        frame_vsync, frame_hsync, frame_href, busy, frame_done;
    logic [7:0]  img_raw;
    logic [15:0] frame_cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_px[$];
    int exp_cnt[$];
    int frames_expected = 0;

    always #5 clk = ~clk;

    raw8_sensor_emu #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .HSYNC_W(2), .H_BACK(2), .H_FRONT(2),
        .VSYNC_W(4), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mirror(mirror),
        .pattern_sel(pattern_sel), .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
        .frame_href(frame_href), .img_raw(img_raw), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference pixel: channel from CFA phase, colour bars by plain division of x.
    function automatic int exp_pix(input int pat, input int mir, input int x, input int y);
        int bar_r[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int bar_g[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int bar_b[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int ch;
        int bar;
        ch  = ((((y & 1) ^ ((mir >> 1) & 1))) << 1) | ((x & 1) ^ (mir & 1));
        bar = x / (HD / 8);
        case (pat)
            0: return (ch == 0) ? 100 : (ch == 3) ? 200 : 150;
            1: begin
                if (ch == 0) return bar_b[bar] ? 255 : 0;
                if (ch == 3) return bar_r[bar] ? 255 : 0;
                return bar_g[bar] ? 255 : 0;
            end
            2: return x & 255;
            default: return (((x >> 3) ^ (y >> 3)) & 1) ? 255 : 0;
        endcase
    endfunction

    task automatic push_frame(input int pat, input int mir);
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                exp_px.push_back(exp_pix(pat, mir, x, y));
        frames_expected++;
        exp_cnt.push_back(frames_expected);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_href) begin
                if (exp_px.size() == 0) check("pixel_unexpected", int'(frame_href), 0);
                else check("pixel", int'(img_raw), exp_px.pop_front());
            end else begin
                check("raw_blank", int'(img_raw), 0);
            end
            if (frame_done) begin
                if (exp_cnt.size() == 0) check("frame_done_unexpected", int'(frame_done), 0);
                else check("frame_cnt", int'(frame_cnt), exp_cnt.pop_front());
            end
        end
    end

    // Runs until frame_done; at the first href burst the next frame's inputs are applied,
    // and at the third burst (line 2) enable takes its next value.
    task automatic run_frame(input int np, input int nm, input bit ne,
                             output int vs_low, output int hs_low, output int hrefs,
                             output int bursts, output int cyc);
        bit prev = 1'b0;
        vs_low = 0; hs_low = 0; hrefs = 0; bursts = 0; cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (!frame_vsync) vs_low++;
            if (!frame_hsync) hs_low++;
            if (frame_href) begin
                hrefs++;
                if (!prev) begin
                    bursts++;
                    if (bursts == 1) begin
                        pattern_sel = 2'(np);
                        mirror      = 2'(nm);
                        if (ne) push_frame(np, nm);
                    end
                    if (bursts == 3) enable = ne;
                end
            end
            prev = frame_href;
            if (frame_done) break;
        end
        check("frame_done_seen", int'(frame_done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vs, hs, hr, bu, cy, viol, bursts;
        bit prev;

        repeat (3) @(negedge clk);
        check("rst_vsync", int'(frame_vsync), 1);
        check("rst_hsync", int'(frame_hsync), 1);
        check("rst_href", int'(frame_href), 0);
        check("rst_raw", int'(img_raw), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_vsync", int'(frame_vsync), 1);

        // Frame 1: flat, mirror 00; timing counts over the whole frame
        pattern_sel = 2'd0;
        mirror      = 2'd0;
        push_frame(0, 0);
        enable = 1'b1;
        run_frame(0, 3, 1'b1, vs, hs, hr, bu, cy);
        check("f1_vsync_low", vs, 4);
        check("f1_hsync_low", hs, 16);
        check("f1_href_cycles", hr, 64);
        check("f1_href_bursts", bu, 4);

        // Frame 2: flat, mirror 11
        run_frame(1, 0, 1'b1, vs, hs, hr, bu, cy);
        check("f2_period", cy, 136);
        check("f2_vsync_low", vs, 4);

        // Frame 3: colour bars
        run_frame(3, 2, 1'b1, vs, hs, hr, bu, cy);
        check("f3_period", cy, 136);

        // Frame 4: checker, mirror 10
        run_frame(0, 1, 1'b1, vs, hs, hr, bu, cy);
        check("f4_period", cy, 136);

        // Frame 5: flat, mirror 01; pattern_sel moves to ramp mid-frame
        run_frame(2, 0, 1'b1, vs, hs, hr, bu, cy);
        check("f5_href_cycles", hr, 64);

        // Frame 6: ramp; enable dropped at line 2, frame must still complete
        run_frame(2, 0, 1'b0, vs, hs, hr, bu, cy);
        check("f6_href_cycles", hr, 64);
        check("f6_period", cy, 136);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || !frame_vsync || frame_href || frame_done) viol++;
        end
        check("idle_after_disable", viol, 0);
        check("cnt_after_disable", int'(frame_cnt), 6);

        // Reset pulsed in the middle of ACTIVE
        pattern_sel = 2'd0;
        mirror      = 2'd0;
        push_frame(0, 0);
        enable = 1'b1;
        bursts = 0;
        prev   = 1'b0;
        for (int i = 0; i < 300 && bursts < 2; i++) begin
            @(negedge clk);
            if (frame_href && !prev) bursts++;
            prev = frame_href;
        end
        check("reset_reached_line1", bursts, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_href", int'(frame_href), 0);
        check("midrst_raw", int'(img_raw), 0);
        check("midrst_cnt", int'(frame_cnt), 0);
        check("midrst_vsync", int'(frame_vsync), 1);
        check("midrst_busy", int'(busy), 0);
        exp_px.delete();
        exp_cnt.delete();
        frames_expected = 0;
        pattern_sel = 2'd1;
        mirror      = 2'd3;
        push_frame(1, 3);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 3, 1'b0, vs, hs, hr, bu, cy);
        check("post_rst_vsync_low", vs, 4);
        check("post_rst_href_cycles", hr, 64);

        repeat (5) @(negedge clk);
        check("px_queue_empty", exp_px.size(), 0);
        check("cnt_queue_empty", exp_cnt.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
